fetch_unit: RTL and testbench

//   IF stage and IF/ID register: the consumer end of the stall/redirect protocol

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_perf_cnt.sv | 19 +
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/stall-control definitions: next-PC codes and the bubble instruction.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_HOLD  = 2'b01,
    PC_JUMP  = 2'b10,
    PC_JALR  = 2'b11
  } pc_ctrl_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating performance counter with enable; sticks at all-ones.
module fetch_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage plus IF/ID register: owns the PC, the imem handshake and bubble injection,
// and applies the next-PC / NOP decisions made by the ID-stage stall logic.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSR = NOP_INSR_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       next_pc_control,
  input  logic             next_nop,
  input  logic             id_is_jalr,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jalr_target,
  output logic [31:0]      imem_addr,
  output logic             imem_req,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      pc_1,
  output logic [31:0]      insr_1,
  output logic             prev_jalr,
  output logic             fetch_stall,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  pc_ctrl_e    ctrl;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        redirect;
  logic        nop_path;
  logic        wait_bubble;
  logic        bubble_en;

  assign ctrl        = pc_ctrl_e'(next_pc_control);
  assign imem_req    = rst_n;
  assign imem_addr   = pc;
  assign fetch_stall = imem_req & ~imem_ready;

  // Jump codes without next_nop are illegal; they still take the bubble path.
  assign redirect    = next_pc_control[1];
  assign nop_path    = next_nop | redirect;
  assign wait_bubble = ~nop_path & (ctrl == PC_PLUS4) & fetch_stall;
  assign bubble_en   = nop_path | wait_bubble;

  always_comb begin
    pc_next = pc;
    case (ctrl)
      PC_PLUS4: pc_next = pc + 32'd4;
      PC_HOLD:  pc_next = pc;
      PC_JUMP:  pc_next = branch_target;
      PC_JALR:  pc_next = jalr_target;
      default:  pc_next = pc;
    endcase
  end

  // PC and IF/ID register; redirects abandon any outstanding fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      pc_1      <= '0;
      insr_1    <= NOP_INSR;
      prev_jalr <= 1'b0;
    end else begin
      prev_jalr <= redirect ? 1'b0 : (id_is_jalr & ~prev_jalr);
      if (nop_path) begin
        insr_1 <= NOP_INSR;
        pc_1   <= pc;
        pc     <= pc_next;
      end else if (ctrl == PC_HOLD) begin
        pc <= pc;
      end else if (fetch_stall) begin
        insr_1 <= NOP_INSR;
        pc_1   <= pc;
      end else begin
        insr_1 <= imem_rdata;
        pc_1   <= pc;
        pc     <= pc_next;
      end
    end
  end

  fetch_perf_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bubble_en),
    .count (bubble_cnt)
  );

  fetch_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (fetch_stall),
    .count (stall_cnt)
  );

`ifndef SYNTHESIS
  a_no_bare_jump: assert property (@(posedge clk) disable iff (!rst_n)
    !(!next_nop && next_pc_control[1]))
    else $error("jump code without next_nop");
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a spec-level model predicts each cycle's IF/ID state.
module tb_fetch_unit;

  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       next_pc_control = 2'b00;
  logic             next_nop = 1'b0;
  logic             id_is_jalr = 1'b0;
  logic [31:0]      branch_target = '0;
  logic [31:0]      jalr_target = '0;
  logic [31:0]      imem_addr;
  logic             imem_req;
  logic [31:0]      imem_rdata = '0;
  logic             imem_ready = 1'b1;
  logic [31:0]      pc_1;
  logic [31:0]      insr_1;
  logic             prev_jalr;
  logic             fetch_stall;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  fetch_unit #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .next_pc_control (next_pc_control),
    .next_nop        (next_nop),
    .id_is_jalr      (id_is_jalr),
    .branch_target   (branch_target),
    .jalr_target     (jalr_target),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .pc_1            (pc_1),
    .insr_1          (insr_1),
    .prev_jalr       (prev_jalr),
    .fetch_stall     (fetch_stall),
    .bubble_cnt      (bubble_cnt),
    .stall_cnt       (stall_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc1;
    logic [31:0] insr;
    logic        pj;
    logic [3:0]  bub;
    logic [3:0]  stl;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // One clock: drive inputs, check combinational outputs, predict, then compare.
  task automatic step(input logic rst, input logic [1:0] code, input logic nop,
                      input logic jalr, input logic [31:0] bt, input logic [31:0] jt,
                      input logic rdy, input logic [31:0] rd);
    exp_t n;
    exp_t got;
    @(negedge clk);
    rst_n = rst; next_pc_control = code; next_nop = nop; id_is_jalr = jalr;
    branch_target = bt; jalr_target = jt; imem_ready = rdy; imem_rdata = rd;
    #1;
    check("imem_req", 32'(imem_req), 32'(rst));
    check("fetch_stall", 32'(fetch_stall), 32'(rst & ~rdy));
    check("imem_addr", imem_addr, m.pc);
    n = m;
    if (!rst) begin
      n.pc = 32'h0; n.pc1 = 32'h0; n.insr = NOP; n.pj = 1'b0; n.bub = 4'd0; n.stl = 4'd0;
    end else begin
      if (!rdy) n.stl = sat_inc(m.stl);
      if (nop || code[1]) begin
        n.insr = NOP; n.pc1 = m.pc; n.bub = sat_inc(m.bub);
        case (code)
          2'b00:   n.pc = m.pc + 32'd4;
          2'b01:   n.pc = m.pc;
          2'b10:   n.pc = bt;
          default: n.pc = jt;
        endcase
        n.pj = code[1] ? 1'b0 : (jalr & ~m.pj);
      end else begin
        n.pj = jalr & ~m.pj;
        if (code == 2'b01) begin
          n.pc = m.pc;
        end else if (!rdy) begin
          n.insr = NOP; n.pc1 = m.pc; n.bub = sat_inc(m.bub);
        end else begin
          n.insr = rd; n.pc1 = m.pc; n.pc = m.pc + 32'd4;
        end
      end
    end
    sb.push_back(n);
    m = n;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("pc", imem_addr, got.pc);
      check("pc_1", pc_1, got.pc1);
      check("insr_1", insr_1, got.insr);
      check("prev_jalr", 32'(prev_jalr), 32'(got.pj));
      check("bubble_cnt", 32'(bubble_cnt), 32'(got.bub));
      check("stall_cnt", 32'(stall_cnt), 32'(got.stl));
    end
  endtask

  task automatic fetch(input logic [31:0] rd);
    step(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, rd);
  endtask

  initial begin
    logic [31:0] saved;
    logic [1:0]  code;
    logic        nop;
    m.pc = 32'h0; m.pc1 = 32'h0; m.insr = NOP; m.pj = 1'b0; m.bub = 4'd0; m.stl = 4'd0;
    @(posedge clk);
    #1;

    // Reset held three cycles
    repeat (3) step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    check("rst_insr", insr_1, 32'h13);
    check("rst_pc", imem_addr, 32'h0);

    // Release: 0,4,8
    fetch(32'hA000_0000);
    check("seq_pc4", imem_addr, 32'h4);
    fetch(32'hA000_0004);
    check("seq_pc8", imem_addr, 32'h8);

    // Load-use hold at 8
    saved = insr_1;
    step(1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBAD0_0008);
    check("hold_pc", imem_addr, 32'h8);
    check("hold_insr", insr_1, saved);
    check("hold_bub", 32'(bubble_cnt), 32'd0);

    fetch(32'hA000_0008);
    fetch(32'hA000_000C);

    // imem wait at 0x10
    repeat (3) step(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hBAD0_0010);
    check("wait_pc", imem_addr, 32'h10);
    check("wait_stall_cnt", 32'(stall_cnt), 32'd3);
    check("wait_insr", insr_1, NOP);
    fetch(32'hA000_0010);
    check("wait_done", insr_1, 32'hA000_0010);

    fetch(32'hA000_0014);
    fetch(32'hA000_0018);
    fetch(32'hA000_001C);

    // JALR at 0x20
    step(1'b1, 2'b01, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 32'hA000_0020);
    check("jalr_hold", imem_addr, 32'h20);
    check("jalr_pj", 32'(prev_jalr), 32'd1);
    step(1'b1, 2'b11, 1'b1, 1'b0, 32'h0, 32'h100, 1'b1, 32'hA000_0020);
    check("jalr_pc", imem_addr, 32'h100);
    check("jalr_bub", 32'(bubble_cnt), 32'd5);

    // Branch to 0x40
    step(1'b1, 2'b10, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hA000_0100);
    check("br_pc", imem_addr, 32'h40);
    check("br_insr", insr_1, NOP);
    fetch(32'hA000_0040);
    check("br_next", imem_addr, 32'h44);

    // Redirect during wait, then wrap past 2^32
    step(1'b1, 2'b10, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0, 32'hBAD0_0044);
    check("redir_pc", imem_addr, 32'hFFFF_FFF8);
    fetch(32'hA000_FFF8);
    fetch(32'hA000_FFFC);
    check("wrap_pc", imem_addr, 32'h0);

    // Random legal traffic; drives the 4-bit counters into saturation
    for (int i = 0; i < 60; i++) begin
      code = 2'($urandom_range(0, 3));
      nop  = code[1] ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'b1, code, nop, 1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), $urandom);
    end
    check("sat_bub", 32'(bubble_cnt), 32'hF);

    // Reset in the middle of an imem wait
    step(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("mid_rst_pc", imem_addr, 32'h0);
    check("mid_rst_stl", 32'(stall_cnt), 32'd0);
    fetch(32'hC000_0000);
    check("mid_rst_restart", imem_addr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
